// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master controller:
//   - command codes presented on the cmd port
//   - controller state encoding
//   - bit positions of the {CPOL,CPHA} mode field
// ---------------------------------------------------------------------------
package spi_pkg;

    // Command codes; codes 6 and 7 are reserved and complete as no-ops.
    localparam logic [2:0] CMD_XFER     = 3'd0;
    localparam logic [2:0] CMD_INIT     = 3'd1;
    localparam logic [2:0] CMD_CS_ON    = 3'd2;
    localparam logic [2:0] CMD_CS_OFF   = 3'd3;
    localparam logic [2:0] CMD_SET_DIV  = 3'd4;
    localparam logic [2:0] CMD_SET_MODE = 3'd5;

    // Mode register layout: mode[1] = CPOL, mode[0] = CPHA.
    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        XFER_HALF0 = 3'd1,
        XFER_HALF1 = 3'd2,
        INIT_RUN   = 3'd3,
        FINISH     = 3'd4
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Loadable down-counter producing a one-cycle half_tick every div+1 clocks.
//
// Ports:
//   clock      system clock
//   reset      synchronous active-high reset
//   enable     counter runs while high
//   load       restarts the half period (counter <= div)
//   div        half-period divider value (half period = div+1 clocks)
//   half_tick  high in the last clock of each half period
// ---------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             half_tick
);

    logic [CNT_W-1:0] count;

    // After a load the counter holds div, so the tick lands div+1 cycles
    // later; each tick reloads automatically to start the next half period.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= div;
        end else if (enable) begin
            if (count == '0) begin
                count <= div;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign half_tick = enable && !load && (count == '0);

endmodule

// File: rtl/spi_master_ctl.sv
// ---------------------------------------------------------------------------
// spi_master_ctl
// Byte-serial SPI master: programmable SCLK divider, SPI modes 0..3,
// NCS active-low chip selects, slow-clock card INIT sequence and an
// idle-timeout flag. One command per start strobe; start is ignored
// while busy.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   start, cmd        command strobe and code (see spi_pkg)
//   cs_sel            chip index for CS_ON (out of range -> all deasserted)
//   din               TX byte / SET_DIV value / SET_MODE {CPOL,CPHA}
//   dout              last received byte
//   busy, done        command in progress / one-cycle completion pulse
//   timeout           idle counter saturated
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   SPI bus
// ---------------------------------------------------------------------------
module spi_master_ctl
    import spi_pkg::*;
#(
    parameter int NCS         = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 1,
    parameter int INIT_DIV    = 124,
    parameter int INIT_CLOCKS = 80,
    parameter int TIMEOUT_CNT = 2500000,
    localparam int SEL_W      = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic [SEL_W-1:0] cs_sel,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [NCS-1:0]   spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int INIT_W = $clog2(INIT_DIV + 1);
    localparam int CNT_W  = (DIV_W > INIT_W) ? DIV_W : INIT_W;
    localparam int HALF_W = $clog2(2 * INIT_CLOCKS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CNT + 1);

    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CNT);
    localparam logic [HALF_W-1:0] INIT_LAST = HALF_W'(2 * INIT_CLOCKS - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic [NCS-1:0]   cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [2:0]       bit_q, bit_d;
    logic [HALF_W-1:0] init_q, init_d;
    logic             done_q, done_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic             cpol;
    logic             cpha;
    logic             div_load;
    logic             div_run;
    logic             use_init_div;
    logic [CNT_W-1:0] div_sel;
    logic             half_tick;

    // One-hot-low decode of cs_sel; an index beyond NCS leaves every line high.
    function automatic logic [NCS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
        logic [NCS-1:0] lines;
        lines = '1;
        for (int i = 0; i < NCS; i++) begin
            if (int'(sel) == i) begin
                lines[i] = 1'b0;
            end
        end
        return lines;
    endfunction

    assign cpol = mode_q[MODE_CPOL_BIT];
    assign cpha = mode_q[MODE_CPHA_BIT];

    // The divider is loaded on the accepting edge, so the source must already
    // reflect the incoming command while still in IDLE.
    assign use_init_div = (state_q == INIT_RUN) ||
                          ((state_q == IDLE) && (cmd == CMD_INIT));
    assign div_sel      = use_init_div ? CNT_W'(INIT_DIV) : CNT_W'(div_q);
    assign div_run      = (state_q == XFER_HALF0) || (state_q == XFER_HALF1) ||
                          (state_q == INIT_RUN);

    spi_clk_div #(
        .CNT_W (CNT_W)
    ) u_clk_div (
        .clock     (clock),
        .reset     (reset),
        .enable    (div_run),
        .load      (div_load),
        .div       (div_sel),
        .half_tick (half_tick)
    );

    // Next-state and datapath logic. Short commands take effect on the
    // accepting edge and park in FINISH for the done cycle; XFER and INIT
    // return straight to IDLE with done raised, so busy is already low
    // in their done cycle.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        mode_d   = mode_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        dout_d   = dout_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        init_d   = init_q;
        done_d   = 1'b0;
        to_d     = to_q;
        div_load = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                to_d = '0;
            end else if (to_q != TO_MAX) begin
                to_d = to_q + TO_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (cmd)
                        CMD_XFER: begin
                            state_d  = XFER_HALF0;
                            tx_d     = din;
                            rx_d     = '0;
                            bit_d    = '0;
                            mosi_d   = din[7];
                            div_load = 1'b1;
                            // CPHA=1 opens each bit with the leading edge.
                            sclk_d   = cpha ? ~cpol : cpol;
                        end
                        CMD_INIT: begin
                            state_d  = INIT_RUN;
                            cs_n_d   = '1;
                            mosi_d   = 1'b1;
                            sclk_d   = cpol;
                            init_d   = '0;
                            div_load = 1'b1;
                        end
                        CMD_CS_ON: begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            cs_n_d  = cs_decode(cs_sel);
                        end
                        CMD_CS_OFF: begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            cs_n_d  = '1;
                        end
                        CMD_SET_DIV: begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            div_d   = DIV_W'(din);
                        end
                        CMD_SET_MODE: begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            mode_d  = din[1:0];
                            sclk_d  = din[MODE_CPOL_BIT];
                        end
                        default: begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            // End of the first half: the sampling edge for CPHA=0 is the
            // leading edge, for CPHA=1 the trailing edge; either way miso is
            // captured here.
            XFER_HALF0: begin
                if (half_tick) begin
                    state_d = XFER_HALF1;
                    rx_d    = {rx_q[6:0], spi_miso};
                    sclk_d  = cpha ? cpol : ~cpol;
                end
            end

            XFER_HALF1: begin
                if (half_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = rx_q;
                        mosi_d  = 1'b0;
                        sclk_d  = cpol;
                    end else begin
                        state_d = XFER_HALF0;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        sclk_d  = cpha ? ~cpol : cpol;
                    end
                end
            end

            // Every tick is one SCLK half period; 2*INIT_CLOCKS halves make
            // the required number of full pulses and end back at CPOL.
            INIT_RUN: begin
                if (half_tick) begin
                    if (init_q == INIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                        sclk_d  = cpol;
                    end else begin
                        init_d = init_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset is synchronous and puts the timeout counter at
    // saturation so timeout reads 1 straight out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(DIV_RESET);
            mode_q  <= 2'b00;
            cs_n_q  <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dout_q  <= 8'h00;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            bit_q   <= 3'd0;
            init_q  <= '0;
            done_q  <= 1'b0;
            to_q    <= TO_MAX;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dout_q  <= dout_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            init_q  <= init_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign timeout  = (to_q == TO_MAX);
    assign dout     = dout_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctl
// Directed stimulus with a response scoreboard (dout, completion latency,
// busy and chip selects at done) and a bit scoreboard (mosi and chip
// selects at each rising SCLK edge). A simple SPI slave model drives miso.
// ---------------------------------------------------------------------------
module tb_spi_master_ctl;
    import spi_pkg::*;

    localparam int NCS         = 2;
    localparam int DIV_W       = 8;
    localparam int DIV_RESET   = 1;
    localparam int INIT_DIV    = 124;
    localparam int INIT_CLOCKS = 80;
    localparam int TIMEOUT_CNT = 300;
    localparam int BUDGET      = 25000;

    logic           clock  = 1'b0;
    logic           reset  = 1'b1;
    logic           start  = 1'b0;
    logic [2:0]     cmd    = 3'd0;
    logic [0:0]     cs_sel = 1'b0;
    logic [7:0]     din    = 8'h00;
    logic [7:0]     dout;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [NCS-1:0] spi_cs_n;
    logic           spi_sclk;
    logic           spi_mosi;
    logic           spi_miso;

    typedef struct {
        logic [7:0]     dout;
        int             lat;
        logic           busy;
        logic [NCS-1:0] cs;
    } resp_t;

    typedef struct {
        logic           mosi;
        logic [NCS-1:0] cs;
    } bit_t;

    resp_t resp_q[$];
    bit_t  bit_q[$];
    resp_t r;
    bit_t  b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_rise_cyc = 0;
    int   sclk_rise_cyc = 0;
    logic prev_busy = 1'b0;
    bit   mosi_chk_en = 1'b0;
    bit   init_active = 1'b0;
    logic [7:0] last_dout = 8'h00;

    logic [7:0] slave_sh   = 8'h00;
    logic       slave_out  = 1'b0;
    logic       slave_cpol = 1'b0;
    logic       slave_cpha = 1'b0;

    assign spi_miso = slave_out;

    spi_master_ctl #(
        .NCS         (NCS),
        .DIV_W       (DIV_W),
        .DIV_RESET   (DIV_RESET),
        .INIT_DIV    (INIT_DIV),
        .INIT_CLOCKS (INIT_CLOCKS),
        .TIMEOUT_CNT (TIMEOUT_CNT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .cmd      (cmd),
        .cs_sel   (cs_sel),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s", name);
    endtask

    // Slave: CPHA=0 shifts on the trailing edge (first bit preloaded),
    // CPHA=1 presents each bit on the leading edge.
    always @(spi_sclk) begin
        if (spi_sclk !== slave_cpol) begin
            if (slave_cpha) begin
                slave_out = slave_sh[7];
                slave_sh  = {slave_sh[6:0], 1'b0};
            end
        end else begin
            if (!slave_cpha) begin
                slave_out = slave_sh[7];
                slave_sh  = {slave_sh[6:0], 1'b0};
            end
        end
    end

    task automatic slavePreload(input logic [7:0] v, input logic pol, input logic pha);
        slave_cpol = pol;
        slave_cpha = pha;
        if (pha) begin
            slave_sh  = v;
            slave_out = 1'b0;
        end else begin
            slave_out = v[7];
            slave_sh  = {v[6:0], 1'b0};
        end
    endtask

    // Response monitor.
    always @(negedge clock) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise_cyc = cyc;
        prev_busy = busy;
        if (done === 1'b1) begin
            if (resp_q.size() == 0) begin
                reportFail("done with no pending command");
            end else begin
                r = resp_q.pop_front();
                checkOutput("dout at done", dout, r.dout);
                checkOutput("done latency", cyc - busy_rise_cyc, r.lat);
                checkOutput("busy at done", busy, r.busy);
                checkOutput("cs_n at done", spi_cs_n, r.cs);
            end
        end
    end

    // Bit monitor on rising SCLK (sampling edge in modes 0 and 3, and every
    // INIT pulse).
    always @(posedge spi_sclk) begin
        sclk_rise_cyc = cyc;
        if (mosi_chk_en) begin
            if (bit_q.size() == 0) begin
                reportFail("unexpected sclk rising edge");
            end else begin
                b = bit_q.pop_front();
                checkOutput("mosi at sclk rise", spi_mosi, b.mosi);
                checkOutput("cs_n at sclk rise", spi_cs_n, b.cs);
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (init_active) checkOutput("init sclk high period", cyc - sclk_rise_cyc, INIT_DIV + 1);
    end

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        if (busy !== 1'b0) reportFail("busy did not clear within budget");
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic [7:0] d, input logic [0:0] sel,
                                 input bit push, input logic [7:0] exp_dout, input int exp_lat,
                                 input logic exp_busy, input logic [NCS-1:0] exp_cs);
        resp_t e;
        @(negedge clock);
        waitIdle();
        if (push) begin
            e.dout = exp_dout;
            e.lat  = exp_lat;
            e.busy = exp_busy;
            e.cs   = exp_cs;
            resp_q.push_back(e);
        end
        start  = 1'b1;
        cmd    = c;
        din    = d;
        cs_sel = sel;
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic pushBits(input logic [7:0] v, input logic [NCS-1:0] cs);
        bit_t e;
        for (int i = 7; i >= 0; i--) begin
            e.mosi = v[i];
            e.cs   = cs;
            bit_q.push_back(e);
        end
    endtask

    task automatic doXfer(input logic [7:0] tx, input logic [7:0] sv, input logic pol,
                          input logic pha, input int lat, input logic [NCS-1:0] cs);
        @(negedge clock);
        waitIdle();
        slavePreload(sv, pol, pha);
        pushBits(tx, cs);
        last_dout = sv;
        applyStimulus(CMD_XFER, tx, 1'b0, 1'b1, sv, lat, 1'b0, cs);
    endtask

    task automatic shortCmd(input logic [2:0] c, input logic [7:0] d, input logic [0:0] sel,
                            input logic [NCS-1:0] cs);
        applyStimulus(c, d, sel, 1'b1, last_dout, 0, 1'b1, cs);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset cs_n", spi_cs_n, 2'b11);
        checkOutput("reset sclk", spi_sclk, 1'b0);
        checkOutput("reset mosi", spi_mosi, 1'b0);
        checkOutput("reset dout", dout, 8'h00);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset timeout", timeout, 1'b1);

        // Idle timeout restarts on an accepted command.
        shortCmd(CMD_SET_MODE, 8'h00, 1'b0, 2'b11);
        checkOutput("timeout after start", timeout, 1'b0);
        repeat (TIMEOUT_CNT / 2) @(negedge clock);
        checkOutput("timeout mid count", timeout, 1'b0);
        repeat (TIMEOUT_CNT / 2 + 5) @(negedge clock);
        checkOutput("timeout saturated", timeout, 1'b1);

        // Mode 0, div=1, CS0 selected.
        shortCmd(CMD_SET_DIV, 8'd1, 1'b0, 2'b11);
        shortCmd(CMD_CS_ON, 8'h00, 1'b0, 2'b10);
        mosi_chk_en = 1'b1;
        doXfer(8'hA5, 8'h3C, 1'b0, 1'b0, 32, 2'b10);

        // A CS_ON strobe during the transfer must be ignored.
        doXfer(8'h5A, 8'hC3, 1'b0, 1'b0, 32, 2'b10);
        repeat (5) @(negedge clock);
        start  = 1'b1;
        cmd    = CMD_CS_ON;
        cs_sel = 1'b1;
        @(negedge clock);
        start  = 1'b0;

        // INIT: 80 pulses at the init divider, mosi high, all CS high.
        @(negedge clock);
        waitIdle();
        init_active = 1'b1;
        for (int i = 0; i < INIT_CLOCKS; i++) begin
            b.mosi = 1'b1;
            b.cs   = 2'b11;
            bit_q.push_back(b);
        end
        applyStimulus(CMD_INIT, 8'h00, 1'b0, 1'b1, last_dout,
                      2 * INIT_CLOCKS * (INIT_DIV + 1), 1'b0, 2'b11);
        waitIdle();
        init_active = 1'b0;
        checkOutput("sclk after init", spi_sclk, 1'b0);
        checkOutput("cs_n after init", spi_cs_n, 2'b11);

        // Divider survives INIT: still 32 cycles per byte.
        doXfer(8'h96, 8'h69, 1'b0, 1'b0, 32, 2'b11);
        shortCmd(CMD_CS_ON, 8'h00, 1'b1, 2'b01);
        shortCmd(CMD_CS_OFF, 8'h00, 1'b0, 2'b11);
        shortCmd(3'd6, 8'hFF, 1'b0, 2'b11);

        // Mode 3 at div=0.
        @(negedge clock);
        waitIdle();
        mosi_chk_en = 1'b0;
        shortCmd(CMD_SET_MODE, 8'h03, 1'b0, 2'b11);
        shortCmd(CMD_SET_DIV, 8'h00, 1'b0, 2'b11);
        @(negedge clock);
        waitIdle();
        checkOutput("sclk idle cpol=1", spi_sclk, 1'b1);
        mosi_chk_en = 1'b1;
        doXfer(8'hFF, 8'h81, 1'b1, 1'b1, 16, 2'b11);

        // Reset in the middle of a transfer.
        @(negedge clock);
        waitIdle();
        mosi_chk_en = 1'b0;
        slavePreload(8'h55, 1'b1, 1'b1);
        applyStimulus(CMD_XFER, 8'h0F, 1'b0, 1'b0, 8'h00, 0, 1'b0, 2'b11);
        repeat (8) @(negedge clock);
        resp_q.delete();
        bit_q.delete();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_dout = 8'h00;
        checkOutput("abort cs_n", spi_cs_n, 2'b11);
        checkOutput("abort sclk", spi_sclk, 1'b0);
        checkOutput("abort mosi", spi_mosi, 1'b0);
        checkOutput("abort dout", dout, 8'h00);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort done", done, 1'b0);
        checkOutput("abort timeout", timeout, 1'b1);

        // Normal transfer after reset: mode 0, reset divider.
        mosi_chk_en = 1'b1;
        doXfer(8'h3C, 8'hA5, 1'b0, 1'b0, 32, 2'b11);

        @(negedge clock);
        waitIdle();
        repeat (3) @(negedge clock);
        checkOutput("responses outstanding", resp_q.size(), 0);
        checkOutput("bits outstanding", bit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
